// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the oversampling ratio
// used by both the receiver and the transmitter.
package uart_pkg;

    localparam int OVERSAMPLE  = 16;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } uart_state_e;

    // Narrower data words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity_of(input logic [7:0] data, input int mode);
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_holding.sv
// One-entry holding buffer in front of the transmit shift register; writes are only
// accepted while empty, so a write to a full buffer is silently dropped.
module uart_tx_holding #(
    parameter int NBITS_DATA = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_write,
    input  logic [NBITS_DATA-1:0] i_data,
    input  logic                  i_take,
    output logic [NBITS_DATA-1:0] o_data,
    output logic                  o_full,
    output logic                  o_ready
);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_full <= 1'b0;
            o_data <= '0;
        end else if (i_write && !o_full) begin
            o_full <= 1'b1;
            o_data <= i_data;
        end else if (i_take) begin
            o_full <= 1'b0;
        end
    end

    assign o_ready = ~o_full;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity and stop bits, each bit
// timed by 16 baud ticks; a holding buffer lets the next byte queue up during a frame.
module uart_tx
    import uart_pkg::*;
#(
    parameter int NBITS_DATA   = 8,
    parameter int STOPBITS_TCK = 16,
    parameter int PARITY       = 0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_tick_brg,
    input  logic                  i_tx_start,
    input  logic [NBITS_DATA-1:0] i_data,
    output logic                  o_tx_ready,
    output logic                  o_tx,
    output logic                  o_tx_done,
    output logic                  o_busy
);

    localparam int TICK_W = $clog2(STOPBITS_TCK > OVERSAMPLE ? STOPBITS_TCK : OVERSAMPLE);
    localparam int IDX_W  = $clog2(NBITS_DATA);

    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOPBITS_TCK - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NBITS_DATA - 1);

    uart_state_e           state;
    logic [TICK_W-1:0]     tick_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [NBITS_DATA-1:0] shift_reg;
    logic                  parity_bit;

    logic                  hold_full;
    logic [NBITS_DATA-1:0] hold_data;
    logic                  take;
    logic                  bit_end;
    logic                  stop_end;

    uart_tx_holding #(
        .NBITS_DATA(NBITS_DATA)
    ) u_holding (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_write (i_tx_start),
        .i_data  (i_data),
        .i_take  (take),
        .o_data  (hold_data),
        .o_full  (hold_full),
        .o_ready (o_tx_ready)
    );

    assign bit_end  = i_tick_brg && (tick_cnt == BIT_LAST);
    assign stop_end = i_tick_brg && (tick_cnt == STOP_LAST);

    // The buffer drains exactly on the edges where the FSM enters START.
    assign take = hold_full && ((state == ST_IDLE) || (state == ST_STOP && stop_end));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            o_tx       <= 1'b1;
            o_tx_done  <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_tx_done <= 1'b0;

            // Parity is latched from the whole byte here, not rebuilt from shifted bits.
            if (take) begin
                shift_reg  <= hold_data;
                parity_bit <= parity_of(8'(hold_data), PARITY);
            end

            case (state)
                ST_IDLE: begin
                    tick_cnt <= '0;
                    if (hold_full) begin
                        state  <= ST_START;
                        o_tx   <= 1'b0;
                        o_busy <= 1'b1;
                    end
                end

                ST_START: begin
                    if (bit_end) begin
                        state    <= ST_DATA;
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                        o_tx     <= shift_reg[0];
                    end else if (i_tick_brg) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        tick_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            if (PARITY != PARITY_NONE) begin
                                state <= ST_PAR;
                                o_tx  <= parity_bit;
                            end else begin
                                state <= ST_STOP;
                                o_tx  <= 1'b1;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= {1'b0, shift_reg[NBITS_DATA-1:1]};
                            o_tx      <= shift_reg[1];
                        end
                    end else if (i_tick_brg) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                ST_PAR: begin
                    if (bit_end) begin
                        state    <= ST_STOP;
                        tick_cnt <= '0;
                        o_tx     <= 1'b1;
                    end else if (i_tick_brg) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (stop_end) begin
                        o_tx_done <= 1'b1;
                        tick_cnt  <= '0;
                        if (hold_full) begin
                            state <= ST_START;
                            o_tx  <= 1'b0;
                        end else begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                        end
                    end else if (i_tick_brg) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    tick_cnt <= '0;
                    o_tx     <= 1'b1;
                    o_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
